input_port_fifo: RTL and testbench

//  Per-direction input buffer of the 5-port router; the producer side of the

---
 rtl/noc_pkg.sv | 23 ++
 rtl/input_port_fifo.sv | 87 ++++++++
 tb/tb_input_port_fifo.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared types for the 5-port mesh router: address layout and port indices.
package noc_pkg;

  localparam int ADDR_W = 8;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } noc_addr_t;

  typedef enum logic [2:0] {
    PORT_N,
    PORT_S,
    PORT_E,
    PORT_W,
    PORT_L
  } port_e;

  function automatic noc_addr_t addr_of(input logic [ADDR_W-1:0] bits);
    return noc_addr_t'(bits);
  endfunction

endpackage

// File: rtl/input_port_fifo.sv
// Per-direction first-word-fall-through input buffer of the router; the head
// packet and its destination address are presented to the route controller.
module input_port_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          data_i,
  output logic                       full_o,
  input  logic                       pop_i,
  output logic                       packet_valid_o,
  output noc_addr_t                  packet_addr_o,
  output logic [DATA_W-1:0]          data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic              r_overflow;
  logic              r_underflow;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_empty;
  logic              w_full;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic [AW-1:0]     w_wr_idx;
  logic [AW-1:0]     w_rd_idx;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];

  // Extra wrap bit distinguishes full (same slot, other lap) from empty.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // A pop in the same cycle frees the head slot, so a full buffer may still accept.
  assign w_push_ok = push_i && (!w_full || pop_i);
  assign w_pop_ok  = pop_i && !w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (push_i && w_full && !pop_i) begin
        r_overflow <= 1'b1;
      end
      if (pop_i && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[w_wr_idx] <= data_i;
    end
  end

  assign full_o         = w_full;
  assign packet_valid_o = !w_empty;
  assign count_o        = r_wr_ptr - r_rd_ptr;
  assign data_o         = r_mem[w_rd_idx];
  assign packet_addr_o  = addr_of(data_o[ADDR_W-1:0]);
  assign overflow_o     = r_overflow;
  assign underflow_o    = r_underflow;

endmodule

// File: tb/tb_input_port_fifo.sv
// Directed bench for the router input buffer: FWFT head, full/overflow,
// push-through-full, wrap streaming, underflow and asynchronous reset.
module tb_input_port_fifo;
  import noc_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              push_i;
  logic [DATA_W-1:0] data_i;
  logic              full_o;
  logic              pop_i;
  logic              packet_valid_o;
  noc_addr_t         packet_addr_o;
  logic [DATA_W-1:0] data_o;
  logic [2:0]        count_o;
  logic              overflow_o;
  logic              underflow_o;

  int n_cmp = 0;
  int n_err = 0;

  input_port_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .push_i         (push_i),
    .data_i         (data_i),
    .full_o         (full_o),
    .pop_i          (pop_i),
    .packet_valid_o (packet_valid_o),
    .packet_addr_o  (packet_addr_o),
    .data_o         (data_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    push_i = 1'b0;
    pop_i  = 1'b0;
    data_i = '0;
    rst    = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (packet_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", packet_valid_o); end
    n_cmp++;
    if (full_o !== 1'b0) begin n_err++; $display("FAIL rst_full got %b want 0", full_o); end
    n_cmp++;
    if (count_o !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", count_o); end
    n_cmp++;
    if ({overflow_o, underflow_o} !== 2'b00) begin n_err++; $display("FAIL rst_flags got %b want 00", {overflow_o, underflow_o}); end
  endtask

  task automatic test_single();
    push_i = 1'b1; data_i = 32'hA500_0021;
    step();
    push_i = 1'b0;
    n_cmp++;
    if (packet_valid_o !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", packet_valid_o); end
    n_cmp++;
    if (packet_addr_o !== 8'h21) begin n_err++; $display("FAIL single_addr got %h want 21", packet_addr_o); end
    n_cmp++;
    if (count_o !== 3'd1) begin n_err++; $display("FAIL single_count got %0d want 1", count_o); end
    n_cmp++;
    if (data_o !== 32'hA500_0021) begin n_err++; $display("FAIL single_data got %h want A5000021", data_o); end
    pop_i = 1'b1;
    step();
    pop_i = 1'b0;
    n_cmp++;
    if (packet_valid_o !== 1'b0) begin n_err++; $display("FAIL single_pop_valid got %b want 0", packet_valid_o); end
    n_cmp++;
    if (count_o !== 3'd0) begin n_err++; $display("FAIL single_pop_count got %0d want 0", count_o); end
  endtask

  task automatic test_fill_overflow();
    logic [31:0] d [4];
    d[0] = 32'h1111_0010; d[1] = 32'h2222_0021;
    d[2] = 32'h3333_0032; d[3] = 32'h4444_0043;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      push_i = 1'b1; data_i = d[i];
      step();
    end
    push_i = 1'b0;
    n_cmp++;
    if (full_o !== 1'b1) begin n_err++; $display("FAIL fill_full got %b want 1", full_o); end
    n_cmp++;
    if (count_o !== 3'd4) begin n_err++; $display("FAIL fill_count got %0d want 4", count_o); end
    push_i = 1'b1; data_i = 32'hDEAD_BEEF;
    step();
    push_i = 1'b0;
    n_cmp++;
    if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", overflow_o); end
    n_cmp++;
    if (count_o !== 3'd4) begin n_err++; $display("FAIL ovf_count got %0d want 4", count_o); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (data_o !== d[i]) begin n_err++; $display("FAIL drain_data[%0d] got %h want %h", i, data_o, d[i]); end
      pop_i = 1'b1;
      step();
    end
    pop_i = 1'b0;
    n_cmp++;
    if (packet_valid_o !== 1'b0) begin n_err++; $display("FAIL drain_valid got %b want 0", packet_valid_o); end
    n_cmp++;
    if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow_o); end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] d [5];
    d[0] = 32'hA000_0001; d[1] = 32'hA000_0012; d[2] = 32'hA000_0023;
    d[3] = 32'hA000_0034; d[4] = 32'hA000_0045;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      push_i = 1'b1; data_i = d[i];
      step();
    end
    push_i = 1'b1; pop_i = 1'b1; data_i = d[4];
    step();
    push_i = 1'b0; pop_i = 1'b0;
    n_cmp++;
    if (count_o !== 3'd4) begin n_err++; $display("FAIL pp_count got %0d want 4", count_o); end
    n_cmp++;
    if (full_o !== 1'b1) begin n_err++; $display("FAIL pp_full got %b want 1", full_o); end
    n_cmp++;
    if (overflow_o !== 1'b0) begin n_err++; $display("FAIL pp_ovf got %b want 0", overflow_o); end
    for (int i = 1; i < 5; i++) begin
      n_cmp++;
      if (data_o !== d[i]) begin n_err++; $display("FAIL pp_data[%0d] got %h want %h", i, data_o, d[i]); end
      pop_i = 1'b1;
      step();
    end
    pop_i = 1'b0;
    n_cmp++;
    if (count_o !== 3'd0) begin n_err++; $display("FAIL pp_final_count got %0d want 0", count_o); end
  endtask

  task automatic test_back_to_back();
    int maxc = 0;
    apply_reset();
    for (int k = 0; k <= 10; k++) begin
      if (k >= 1) begin
        n_cmp++;
        if (data_o !== (32'hC000_0000 + 32'(k - 1))) begin
          n_err++; $display("FAIL stream_data[%0d] got %h want %h", k - 1, data_o, 32'hC000_0000 + 32'(k - 1));
        end
      end
      push_i = (k < 10);
      data_i = 32'hC000_0000 + 32'(k);
      pop_i  = (k >= 1);
      step();
      if (int'(count_o) > maxc) maxc = int'(count_o);
    end
    push_i = 1'b0; pop_i = 1'b0;
    n_cmp++;
    if (maxc > 2) begin n_err++; $display("FAIL stream_maxcount got %0d want <=2", maxc); end
    n_cmp++;
    if (count_o !== 3'd0) begin n_err++; $display("FAIL stream_count got %0d want 0", count_o); end
    n_cmp++;
    if ({overflow_o, underflow_o} !== 2'b00) begin n_err++; $display("FAIL stream_flags got %b want 00", {overflow_o, underflow_o}); end
  endtask

  task automatic test_underflow();
    apply_reset();
    pop_i = 1'b1;
    step();
    n_cmp++;
    if (underflow_o !== 1'b1) begin n_err++; $display("FAIL unf_flag got %b want 1", underflow_o); end
    n_cmp++;
    if (count_o !== 3'd0) begin n_err++; $display("FAIL unf_count got %0d want 0", count_o); end
    push_i = 1'b1; data_i = 32'h5555_0077;
    step();
    push_i = 1'b0; pop_i = 1'b0;
    n_cmp++;
    if (count_o !== 3'd1) begin n_err++; $display("FAIL unf_pp_count got %0d want 1", count_o); end
    n_cmp++;
    if (data_o !== 32'h5555_0077) begin n_err++; $display("FAIL unf_pp_data got %h want 55550077", data_o); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    pop_i = 1'b1;
    step();
    pop_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_i = 1'b1; data_i = 32'hE000_0000 + 32'(i);
      step();
    end
    push_i = 1'b0;
    n_cmp++;
    if (count_o !== 3'd3) begin n_err++; $display("FAIL ar_pre_count got %0d want 3", count_o); end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (packet_valid_o !== 1'b0) begin n_err++; $display("FAIL ar_valid got %b want 0", packet_valid_o); end
    n_cmp++;
    if (full_o !== 1'b0) begin n_err++; $display("FAIL ar_full got %b want 0", full_o); end
    n_cmp++;
    if (count_o !== 3'd0) begin n_err++; $display("FAIL ar_count got %0d want 0", count_o); end
    n_cmp++;
    if ({overflow_o, underflow_o} !== 2'b00) begin n_err++; $display("FAIL ar_flags got %b want 00", {overflow_o, underflow_o}); end
    #1;
    rst = 1'b1;
    step();
    test_single();
  endtask

  initial begin
    rst    = 1'b0;
    push_i = 1'b0;
    pop_i  = 1'b0;
    data_i = '0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_push_pop_full();
    test_back_to_back();
    test_underflow();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
